// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared types, default sizes and helpers for the APB initiator
package apb_master_pkg;
  localparam int COMP_DEF = 4;
  localparam int ADDR_DEF = 7;
  localparam int COEFF_DEF = 20;
  localparam int WAIT_MAX_DEF = 16;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERRDONE} state_t;
  typedef struct packed {
    logic                 write;
    logic [COMP_DEF-1:0]  sel;
    logic [ADDR_DEF-1:0]  addr;
    logic [COEFF_DEF-1:0] wdata;
  } req_t;
  function automatic logic is_onehot(input logic [COMP_DEF-1:0] s);
    return (s != '0) && ((s & (s - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/apb_req_capture.sv
// apb_req_capture: MTRANS edge detect plus active/pending request slots and overflow flag
//   mtrans/req : host strobe and request fields
//   fin        : FSM can retire the current slot this edge
//   act        : request currently driven on APB
//   load       : a new request enters the active slot this edge
//   nxt_ok     : the request about to be loaded has a one-hot select
//   pend_v     : pending slot occupied
//   movr       : sticky, a request arrived while the pending slot was full
module apb_req_capture
  import apb_master_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic mtrans,
  input  logic fin,
  input  req_t req,
  output req_t act,
  output logic load,
  output logic nxt_ok,
  output logic pend_v,
  output logic movr
);
  logic mtrans_q, ev;
  req_t pend, nxt;
  assign ev = mtrans & ~mtrans_q;
  // pending request always has priority over a simultaneous new event
  assign nxt = pend_v ? pend : req;
  assign load = fin & (pend_v | ev);
  assign nxt_ok = is_onehot(nxt.sel);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mtrans_q <= 1'b0;
      act <= '0;
      pend <= '0;
      pend_v <= 1'b0;
      movr <= 1'b0;
    end else begin
      mtrans_q <= mtrans;
      if (load) act <= nxt;
      if (load && pend_v) begin
        pend <= req;
        pend_v <= ev;
      end else if (ev && !fin) begin
        if (pend_v) movr <= 1'b1;
        else begin
          pend <= req;
          pend_v <= 1'b1;
        end
      end
    end
endmodule

// File: rtl/apb_master.sv
// apb_master: converts strobed host requests into APB SETUP/ACCESS transfers with timeout
//   host side : MTRANS/MWRITE/MSELx/MADDR/MWDATA in; MRDATA/MBUSY/MDONE/MERR/MOVR out
//   APB side  : PSELx/PENABLE/PWRITE/PADDR/PWDATA out; PRDATA/PREADY/PSLVERR in
module apb_master
  import apb_master_pkg::*;
#(
  parameter int PDATA_WIDTH = 32,
  parameter int ADDR_WIDTH = ADDR_DEF,
  parameter int COEFF_WIDTH = COEFF_DEF,
  parameter int COMP = COMP_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   MTRANS,
  input  logic                   MWRITE,
  input  logic [COMP-1:0]        MSELx,
  input  logic [ADDR_WIDTH-1:0]  MADDR,
  input  logic [COEFF_WIDTH-1:0] MWDATA,
  output logic [PDATA_WIDTH-1:0] MRDATA,
  output logic                   MBUSY,
  output logic                   MDONE,
  output logic                   MERR,
  output logic                   MOVR,
  output logic [COMP-1:0]        PSELx,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_WIDTH-1:0]  PADDR,
  output logic [PDATA_WIDTH-1:0] PWDATA,
  input  logic [PDATA_WIDTH-1:0] PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  state_t state, state_n;
  req_t req, act;
  logic load, nxt_ok, pend_v, fin, cmp, tmo, done_q, err_q;
  logic [CW-1:0] cnt;
  assign req = '{write: MWRITE, sel: MSELx, addr: MADDR, wdata: MWDATA};
  apb_req_capture u_cap (
    .clk(clk), .rst_n(rst_n), .mtrans(MTRANS), .fin(fin), .req(req),
    .act(act), .load(load), .nxt_ok(nxt_ok), .pend_v(pend_v), .movr(MOVR)
  );
  // the cycle that would be the WAIT_MAX-th stalled ACCESS cycle ends the transfer
  assign tmo = ~PREADY & (cnt == CW'(WAIT_MAX - 1));
  assign cmp = (state == ACCESS) & (PREADY | tmo);
  assign fin = (state == IDLE) | (state == ERRDONE) | cmp;
  always_comb begin
    state_n = state;
    state_n = state == SETUP ? ACCESS : !fin ? state : !load ? IDLE : nxt_ok ? SETUP : ERRDONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      MRDATA <= '0;
    end else begin
      state <= state_n;
      cnt <= state == SETUP ? '0 : (state == ACCESS && !PREADY) ? cnt + 1'b1 : cnt;
      done_q <= cmp;
      err_q <= cmp & (tmo | PSLVERR);
      if (cmp && !act.write) MRDATA <= (tmo | PSLVERR) ? '0 : PRDATA;
    end
  assign MDONE = done_q | (state == ERRDONE);
  assign MERR = err_q | (state == ERRDONE);
  assign MBUSY = (state != IDLE) | pend_v;
  assign PSELx = (state == SETUP || state == ACCESS) ? act.sel : '0;
  assign PENABLE = state == ACCESS;
  assign PWRITE = act.write;
  assign PADDR = act.addr;
  assign PWDATA = {{(PDATA_WIDTH - COEFF_WIDTH){act.wdata[COEFF_WIDTH-1]}}, act.wdata};
endmodule
